// File: rtl/rev_counter_ctrl.sv
// Run/pause/load sequencer owning the reversible count register and step prescaler.
// Latency: cnt/dir/state registered (1 clk); tick and rc decoded combinationally in the step cycle.
// Backpressure: none; strobes act in the cycle seen. Priority load > stop > start; losers are dropped.
// Build option: define PINGPONG_EN to bounce at terminal count instead of stopping in DONE.
module rev_counter_ctrl #(
    parameter int WIDTH = 16,
    parameter int DIV   = 10_000_000,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir_sw,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             rc,
    output logic             tick,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] LP_DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] LP_PS_ONE   = DIV_W'(1);
    localparam logic [WIDTH-1:0] LP_ONE      = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] w_presc_nxt;
    logic             w_tick;
    logic             w_rc;
    logic             w_step_due;

    // Terminal count is decoded from registered state only, so it never glitches on inputs
    assign w_rc       = r_dir ? (r_cnt == {WIDTH{1'b1}}) : (r_cnt == {WIDTH{1'b0}});
    assign w_step_due = (r_state == S_RUN) && (r_presc == LP_DIV_LAST);

    // Next-state, count, direction and prescaler decode; load overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_presc_nxt = r_presc;
        w_tick      = 1'b0;

        // Direction follows the switch whenever the counter is not actively running
        if (r_state != S_RUN) begin
            w_dir_nxt = dir_sw;
        end

        // Prescaler advances only while running and wraps on the step cycle
        if (r_state == S_RUN) begin
            w_presc_nxt = w_step_due ? '0 : (r_presc + LP_PS_ONE);
        end

        if (load) begin
            // Preset discards any step landing in the same cycle
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = load_val;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!stop && start) begin
                        w_state_nxt = S_RUN;
                        w_presc_nxt = '0;
                    end
                end
                S_RUN: begin
                    if (w_step_due) begin
                        if (w_rc) begin
`ifdef PINGPONG_EN
                            // Bounce: reverse and take one step in the new direction
                            w_dir_nxt = ~r_dir;
                            w_cnt_nxt = r_dir ? (r_cnt - LP_ONE) : (r_cnt + LP_ONE);
                            w_tick    = 1'b1;
`else
                            // Hold at terminal count; a coincident stop still wins below
                            w_state_nxt = S_DONE;
`endif
                        end else begin
                            w_cnt_nxt = r_dir ? (r_cnt + LP_ONE) : (r_cnt - LP_ONE);
                            w_tick    = 1'b1;
                        end
                    end
                    if (stop) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        w_state_nxt = S_IDLE;
                    end else if (start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_DONE: begin
                    // Restart only if the current direction leads away from the terminal value
                    if (stop) begin
                        w_state_nxt = S_IDLE;
                    end else if (start && !w_rc) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State registers; reset aborts a run with no pending step surviving
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b1;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    assign cnt   = r_cnt;
    assign dir   = r_dir;
    assign rc    = w_rc;
    assign tick  = w_tick;
    assign busy  = (r_state == S_RUN);
    assign state = r_state;

endmodule

// File: tb/tb_rev_counter_ctrl.sv
// Directed bench for rev_counter_ctrl with DIV=4, WIDTH=16.
// Inputs change 1 ns after the rising edge; outputs are observed in that same window.
// Expectations follow the default build unless PINGPONG_EN is defined.
module tb_rev_counter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        load;
    logic [15:0] load_val;
    logic        dir_sw;
    logic [15:0] cnt;
    logic        dir;
    logic        rc;
    logic        tick;
    logic        busy;
    logic [1:0]  state;

    int n_total;
    int n_bad;

    rev_counter_ctrl #(.WIDTH(16), .DIV(4), .DIV_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .dir_sw(dir_sw), .cnt(cnt), .dir(dir), .rc(rc),
        .tick(tick), .busy(busy), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; strobes asserted before the call last exactly that cycle
    task automatic nxt();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        load  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; load_val = 16'h0; dir_sw = 1'b1;
        #12;
        n_total++;
        if ({state, cnt, dir, rc, tick, busy} !== {2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs got st=%b cnt=%h dir=%b rc=%b tick=%b busy=%b want 00/0000/1/0/0/0",
                     state, cnt, dir, rc, tick, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nxt();
    endtask

    // Start from IDLE: a step every 4 cycles, first one 4 cycles after the start strobe
    task automatic test_run_up();
        dir_sw = 1'b1;
        start  = 1'b1;
        nxt();
        n_total++;
        if (busy !== 1'b1 || state !== 2'b01) begin
            n_bad++; $display("FAIL run_busy got busy=%b st=%b want 1/01", busy, state);
        end
        for (int k = 1; k <= 3; k++) begin
            repeat (2) nxt();
            n_total++;
            if (tick !== 1'b0) begin
                n_bad++; $display("FAIL run_early_tick k=%0d got=%b want=0", k, tick);
            end
            nxt();
            n_total++;
            if (tick !== 1'b1 || cnt !== 16'(k - 1)) begin
                n_bad++; $display("FAIL run_tick k=%0d got tick=%b cnt=%h want 1/%h", k, tick, cnt, 16'(k - 1));
            end
            nxt();
            n_total++;
            if (cnt !== 16'(k) || tick !== 1'b0) begin
                n_bad++; $display("FAIL run_cnt k=%0d got cnt=%h tick=%b want %h/0", k, cnt, tick, 16'(k));
            end
        end
    endtask

    // Stop mid-period holds the prescaler; stop on a step cycle still steps
    task automatic test_pause_resume();
        nxt();
        stop = 1'b1;
        nxt();
        n_total++;
        if ({state, busy, cnt} !== {2'b10, 1'b0, 16'h0003}) begin
            n_bad++; $display("FAIL pause_enter got st=%b busy=%b cnt=%h want 10/0/0003", state, busy, cnt);
        end
        repeat (2) nxt();
        start = 1'b1;
        nxt();
        nxt();
        n_total++;
        if (tick !== 1'b1 || cnt !== 16'h0003) begin
            n_bad++; $display("FAIL resume_held_presc got tick=%b cnt=%h want 1/0003", tick, cnt);
        end
        nxt();
        repeat (3) nxt();
        stop = 1'b1;
        #1;
        n_total++;
        if (tick !== 1'b1) begin
            n_bad++; $display("FAIL stop_on_step_tick got=%b want=1", tick);
        end
        nxt();
        n_total++;
        if (state !== 2'b10 || cnt !== 16'h0005) begin
            n_bad++; $display("FAIL stop_on_step got st=%b cnt=%h want 10/0005", state, cnt);
        end
        repeat (2) nxt();
        start = 1'b1;
        nxt();
        repeat (2) nxt();
        n_total++;
        if (tick !== 1'b0) begin
            n_bad++; $display("FAIL resume_early_tick got=%b want=0", tick);
        end
        nxt();
        n_total++;
        if (tick !== 1'b1 || cnt !== 16'h0005) begin
            n_bad++; $display("FAIL resume_tick got tick=%b cnt=%h want 1/0005", tick, cnt);
        end
        nxt();
    endtask

    // Approach the top of range and exercise the terminal step
    task automatic test_terminal();
        load = 1'b1; load_val = 16'hFFFE; dir_sw = 1'b1;
        nxt();
        n_total++;
        if (state !== 2'b00 || cnt !== 16'hFFFE) begin
            n_bad++; $display("FAIL load_preset got st=%b cnt=%h want 00/FFFE", state, cnt);
        end
        start = 1'b1;
        nxt();
        repeat (4) nxt();
        n_total++;
        if (cnt !== 16'hFFFF || rc !== 1'b1) begin
            n_bad++; $display("FAIL reach_ffff got cnt=%h rc=%b want FFFF/1", cnt, rc);
        end
        repeat (3) nxt();
`ifdef PINGPONG_EN
        n_total++;
        if (tick !== 1'b1) begin
            n_bad++; $display("FAIL bounce_tick got=%b want=1", tick);
        end
        nxt();
        n_total++;
        if ({state, cnt, dir} !== {2'b01, 16'hFFFE, 1'b0}) begin
            n_bad++; $display("FAIL bounce got st=%b cnt=%h dir=%b want 01/FFFE/0", state, cnt, dir);
        end
`else
        n_total++;
        if (tick !== 1'b0) begin
            n_bad++; $display("FAIL terminal_tick got=%b want=0", tick);
        end
        nxt();
        n_total++;
        if ({state, cnt, busy} !== {2'b11, 16'hFFFF, 1'b0}) begin
            n_bad++; $display("FAIL done_enter got st=%b cnt=%h busy=%b want 11/FFFF/0", state, cnt, busy);
        end
        start = 1'b1;
        nxt();
        n_total++;
        if (state !== 2'b11) begin
            n_bad++; $display("FAIL done_start_blocked got st=%b want 11", state);
        end
        dir_sw = 1'b0;
        nxt();
        n_total++;
        if (dir !== 1'b0 || rc !== 1'b0) begin
            n_bad++; $display("FAIL done_dir_follow got dir=%b rc=%b want 0/0", dir, rc);
        end
        start = 1'b1;
        nxt();
        n_total++;
        if (state !== 2'b01) begin
            n_bad++; $display("FAIL done_restart got st=%b want 01", state);
        end
        repeat (4) nxt();
        n_total++;
        if (cnt !== 16'hFFFE) begin
            n_bad++; $display("FAIL done_first_step got cnt=%h want FFFE", cnt);
        end
`endif
    endtask

    // All three strobes on a step cycle: load wins and the step is lost
    task automatic test_strobe_priority();
        repeat (3) nxt();
        load = 1'b1; stop = 1'b1; start = 1'b1; load_val = 16'h1234;
        #1;
        n_total++;
        if (tick !== 1'b0) begin
            n_bad++; $display("FAIL prio_tick got=%b want=0", tick);
        end
        nxt();
        n_total++;
        if (state !== 2'b00 || cnt !== 16'h1234) begin
            n_bad++; $display("FAIL prio_load got st=%b cnt=%h want 00/1234", state, cnt);
        end
    endtask

    // Direction is frozen while running and follows the switch again once paused
    task automatic test_dir_freeze();
        dir_sw = 1'b0;
        nxt();
        start = 1'b1;
        nxt();
        dir_sw = 1'b1;
        repeat (2) nxt();
        n_total++;
        if (dir !== 1'b0) begin
            n_bad++; $display("FAIL dir_frozen got=%b want=0", dir);
        end
        nxt();
        nxt();
        n_total++;
        if (cnt !== 16'h1233) begin
            n_bad++; $display("FAIL dir_down_step got cnt=%h want 1233", cnt);
        end
        stop = 1'b1;
        nxt();
        nxt();
        n_total++;
        if (dir !== 1'b1) begin
            n_bad++; $display("FAIL dir_pause_follow got=%b want=1", dir);
        end
    endtask

    // Reset mid-run clears everything immediately and nothing steps after release
    task automatic test_reset_mid_run();
        start = 1'b1;
        nxt();
        repeat (2) nxt();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({state, cnt, dir, rc, tick, busy} !== {2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid_run got st=%b cnt=%h dir=%b rc=%b tick=%b busy=%b want 00/0000/1/0/0/0",
                     state, cnt, dir, rc, tick, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) nxt();
        n_total++;
        if (state !== 2'b00 || cnt !== 16'h0000) begin
            n_bad++; $display("FAIL rst_release got st=%b cnt=%h want 00/0000", state, cnt);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_run_up();
        test_pause_resume();
        test_terminal();
        test_strobe_priority();
        test_dir_freeze();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
